// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised binary floating-point datapath.
package fp_pkg;

    localparam int unsigned FP_MAX_W = 128;

    localparam logic RMODE_RNE = 1'b0;
    localparam logic RMODE_RTZ = 1'b1;

    typedef enum logic [1:0] {ClsZero, ClsNorm, ClsInf, ClsNan} fp_cls_e;

    function automatic int unsigned fp_bias(input int unsigned ew);
        return (32'd1 << (ew - 1)) - 32'd1;
    endfunction

    // Canonical quiet NaN, right-aligned in a FP_MAX_W-bit word.
    function automatic logic [FP_MAX_W-1:0] fp_qnan(input int unsigned ew, input int unsigned mw);
        logic [FP_MAX_W-1:0] one;
        one = FP_MAX_W'(1);
        return (((one << ew) - one) << mw) | (one << (mw - 1));
    endfunction

endpackage

// File: rtl/fp_sig_mul.sv
// Pipelined unsigned significand multiplier: STAGES registers sharing one enable.
module fp_sig_mul #(
    parameter int unsigned SW     = 24,
    parameter int unsigned STAGES = 3
) (
    input  logic              clk,
    input  logic              en,
    input  logic [SW-1:0]     a,
    input  logic [SW-1:0]     b,
    output logic [2*SW-1:0]   p
);

    logic [2*SW-1:0] stage_q [STAGES];

    always_ff @(posedge clk) begin
        if (en) begin
            stage_q[0] <= {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign p = stage_q[STAGES-1];

endmodule

// File: rtl/fp_mul_pipe.sv
// Fully pipelined IEEE-754 multiplier with DAZ/FTZ, RNE/RTZ rounding, flags and back-pressure.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int unsigned EW     = 8,
    parameter int unsigned MW     = 23,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TW     = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ACT,
    output logic                ACK,
    input  logic [EW+MW:0]      A,
    input  logic [EW+MW:0]      B,
    input  logic                RMODE,
    input  logic [TW-1:0]       DSTI,
    input  logic                HOLD,
    output logic                RDY,
    output logic [TW-1:0]       DST,
    output logic [EW+MW:0]      R,
    output logic                ZERO,
    output logic                SIGN,
    output logic                INF,
    output logic                NAN,
    output logic                OVF,
    output logic                UNF,
    output logic                INX
);

    localparam int unsigned W  = EW + MW + 1;
    localparam int unsigned SW = MW + 1;
    localparam int unsigned PW = 2 * SW;
    localparam int unsigned XW = EW + 2;

    localparam logic [FP_MAX_W-1:0] QNAN_FULL = fp_qnan(EW, MW);
    localparam logic [W-1:0]        QNAN      = QNAN_FULL[W-1:0];
    localparam logic signed [XW-1:0] BIAS_X   = XW'(fp_bias(EW));
    localparam logic signed [XW-1:0] EMAX_X   = XW'((32'd1 << EW) - 32'd1);

    typedef struct packed {
        logic                  valid;
        logic [TW-1:0]         tag;
        logic                  rmode;
        logic                  sign;
        fp_cls_e               cls;
        logic signed [XW-1:0]  exp;
    } side_t;

    logic en;
    assign en  = ~(RDY & HOLD);
    assign ACK = en;

    // Unpack
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] fa, fb;
    logic          za, zb, ia, ib, na, nb;
    side_t         side_in;

    assign ea = A[W-2:MW];
    assign eb = B[W-2:MW];
    assign fa = A[MW-1:0];
    assign fb = B[MW-1:0];

    always_comb begin
        za = (ea == '0);
        zb = (eb == '0);
        ia = (&ea) & (fa == '0);
        ib = (&eb) & (fb == '0);
        na = (&ea) & (fa != '0);
        nb = (&eb) & (fb != '0);

        side_in       = '0;
        side_in.valid = ACT;
        side_in.tag   = DSTI;
        side_in.rmode = RMODE;
        side_in.sign  = A[W-1] ^ B[W-1];
        side_in.exp   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_X;
        if (na | nb | (ia & zb) | (za & ib)) begin
            side_in.cls = ClsNan;
        end else if (ia | ib) begin
            side_in.cls = ClsInf;
        end else if (za | zb) begin
            side_in.cls = ClsZero;
        end else begin
            side_in.cls = ClsNorm;
        end
    end

    side_t           side_q [STAGES+1];
    logic [SW-1:0]   sig_a_q, sig_b_q;
    logic [PW-1:0]   prod;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i <= STAGES; i++) begin
                side_q[i] <= '0;
            end
        end else if (en) begin
            side_q[0] <= side_in;
            for (int i = 1; i <= STAGES; i++) begin
                side_q[i] <= side_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (en) begin
            sig_a_q <= {1'b1, fa};
            sig_b_q <= {1'b1, fb};
        end
    end

    fp_sig_mul #(
        .SW     (SW),
        .STAGES (STAGES)
    ) u_sig_mul (
        .clk (CLK),
        .en  (en),
        .a   (sig_a_q),
        .b   (sig_b_q),
        .p   (prod)
    );

    // Round / pack
    side_t                s;
    logic [PW-2:0]        norm;
    logic signed [XW-1:0] e_n, e_r;
    logic [MW-1:0]        mant;
    logic                 guard, sticky, inc;
    logic [MW:0]          mant_r;
    logic [W-1:0]         r_d;
    logic                 zero_d, inf_d, nan_d, ovf_d, unf_d, inx_d;

    always_comb begin
        s      = side_q[STAGES];
        // Product is in [1,4); align so the leading one sits just above norm.
        norm   = prod[PW-1] ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
        e_n    = s.exp + $signed({{(XW-1){1'b0}}, prod[PW-1]});
        mant   = norm[PW-2 -: MW];
        guard  = norm[PW-2-MW];
        sticky = |norm[PW-3-MW:0];
        inc    = (s.rmode == RMODE_RNE) & guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + {{MW{1'b0}}, inc};
        e_r    = e_n + $signed({{(XW-1){1'b0}}, mant_r[MW]});

        r_d    = '0;
        zero_d = 1'b0;
        inf_d  = 1'b0;
        nan_d  = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        inx_d  = 1'b0;

        case (s.cls)
            ClsNan: begin
                r_d   = QNAN;
                nan_d = 1'b1;
            end
            ClsInf: begin
                r_d   = {s.sign, {EW{1'b1}}, {MW{1'b0}}};
                inf_d = 1'b1;
            end
            ClsZero: begin
                r_d    = {s.sign, {(W-1){1'b0}}};
                zero_d = 1'b1;
            end
            default: begin
                if (e_n[XW-1] || (e_n == '0)) begin
                    r_d    = {s.sign, {(W-1){1'b0}}};
                    unf_d  = 1'b1;
                    zero_d = 1'b1;
                    inx_d  = 1'b1;
                end else if (e_r >= EMAX_X) begin
                    ovf_d = 1'b1;
                    inx_d = 1'b1;
                    if (s.rmode == RMODE_RTZ) begin
                        r_d = {s.sign, {(EW-1){1'b1}}, 1'b0, {MW{1'b1}}};
                    end else begin
                        r_d   = {s.sign, {EW{1'b1}}, {MW{1'b0}}};
                        inf_d = 1'b1;
                    end
                end else begin
                    r_d   = {s.sign, e_r[EW-1:0], mant_r[MW-1:0]};
                    inx_d = guard | sticky;
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RDY  <= 1'b0;
            DST  <= '0;
            R    <= '0;
            ZERO <= 1'b0;
            INF  <= 1'b0;
            NAN  <= 1'b0;
            OVF  <= 1'b0;
            UNF  <= 1'b0;
            INX  <= 1'b0;
        end else if (en) begin
            RDY  <= s.valid;
            DST  <= s.tag;
            R    <= r_d;
            ZERO <= zero_d;
            INF  <= inf_d;
            NAN  <= nan_d;
            OVF  <= ovf_d;
            UNF  <= unf_d;
            INX  <= inx_d;
        end
    end

    assign SIGN = R[W-1];

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed corner cases, stall/order/reset scenarios, randomized traffic.
module tb_fp_mul_pipe;

    logic        clk = 1'b0;
    logic        reset, act, ack, rmode, hold, rdy;
    logic [31:0] a, b, r;
    logic [3:0]  dsti, dst;
    logic        zero, sign, inf, nan, ovf, unf, inx;
    logic [6:0]  flags;

    assign flags = {zero, sign, inf, nan, ovf, unf, inx};

    always #5 clk = ~clk;

    fp_mul_pipe #(
        .EW     (8),
        .MW     (23),
        .STAGES (3),
        .TW     (4)
    ) dut (
        .CLK   (clk),
        .RESET (reset),
        .ACT   (act),
        .ACK   (ack),
        .A     (a),
        .B     (b),
        .RMODE (rmode),
        .DSTI  (dsti),
        .HOLD  (hold),
        .RDY   (rdy),
        .DST   (dst),
        .R     (r),
        .ZERO  (zero),
        .SIGN  (sign),
        .INF   (inf),
        .NAN   (nan),
        .OVF   (ovf),
        .UNF   (unf),
        .INX   (inx)
    );

    typedef struct {
        logic [3:0]  tag;
        logic [31:0] r;
        logic [6:0]  flags;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, rounding decided from the remainder against one half ulp.
    function automatic exp_t fp_model(input logic [31:0] x, input logic [31:0] y, input logic rm,
                                      input logic [3:0] tag);
        exp_t              o;
        int                ex, ey, e, sh;
        logic [22:0]       fx, fy;
        logic              zx, zy, ix, iy, nx, ny, sgn, up;
        longint unsigned   p, keep, rem, half;
        o.tag   = tag;
        o.flags = '0;
        o.r     = '0;
        ex  = int'(x[30:23]);
        ey  = int'(y[30:23]);
        fx  = x[22:0];
        fy  = y[22:0];
        sgn = x[31] ^ y[31];
        zx  = (ex == 0);
        zy  = (ey == 0);
        ix  = (ex == 255) && (fx == 0);
        iy  = (ey == 255) && (fy == 0);
        nx  = (ex == 255) && (fx != 0);
        ny  = (ey == 255) && (fy != 0);
        if (nx || ny || (ix && zy) || (zx && iy)) begin
            o.r = 32'h7FC0_0000;
            o.flags[3] = 1'b1;
        end else if (ix || iy) begin
            o.r = {sgn, 8'hFF, 23'h0};
            o.flags[4] = 1'b1;
        end else if (zx || zy) begin
            o.r = {sgn, 31'h0};
            o.flags[6] = 1'b1;
        end else begin
            p  = {40'h1, fx} * {40'h1, fy};
            e  = ex + ey - 127;
            sh = 23;
            if (p >= (64'd1 << 47)) begin
                sh = 24;
                e  = e + 1;
            end
            keep = p >> sh;
            rem  = p - (keep << sh);
            half = 64'd1 << (sh - 1);
            if (e <= 0) begin
                o.r = {sgn, 31'h0};
                o.flags[6] = 1'b1;
                o.flags[1] = 1'b1;
                o.flags[0] = 1'b1;
            end else begin
                up = (rm == 1'b0) && ((rem > half) || ((rem == half) && keep[0]));
                if (up) keep = keep + 1;
                if (keep == (64'd1 << 24)) begin
                    keep = keep >> 1;
                    e    = e + 1;
                end
                if (e >= 255) begin
                    o.flags[2] = 1'b1;
                    o.flags[0] = 1'b1;
                    if (rm == 1'b0) begin
                        o.r = {sgn, 8'hFF, 23'h0};
                        o.flags[4] = 1'b1;
                    end else begin
                        o.r = {sgn, 8'hFE, 23'h7F_FFFF};
                    end
                end else begin
                    o.r = {sgn, e[7:0], keep[22:0]};
                    o.flags[0] = (rem != 0);
                end
            end
        end
        o.flags[5] = o.r[31];
        return o;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int          k;
        k = int'($urandom_range(0, 15));
        f = 23'($urandom);
        case (k)
            0:       e = 8'h00;
            1:       begin e = 8'hFF; f = '0; end
            2:       e = 8'hFF;
            3:       begin e = 8'($urandom_range(100, 154)); f = '1; end
            4:       e = 8'($urandom_range(1, 20));
            5:       e = 8'($urandom_range(235, 254));
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {1'($urandom), e, f};
    endfunction

    // One cycle: drive at the falling edge, then score what the next rising edge will do.
    task automatic step(input logic act_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input logic rm_v, input logic [3:0] tag_v, input logic hold_v,
                        input logic rst_v, output logic taken, output logic consumed);
        exp_t e;
        @(negedge clk);
        act   = act_v;
        a     = a_v;
        b     = b_v;
        rmode = rm_v;
        dsti  = tag_v;
        hold  = hold_v;
        reset = rst_v;
        #1;
        taken    = act & ack & ~reset;
        consumed = rdy & ~hold & ~reset;
        if (reset) begin
            sb.delete();
        end else begin
            if (consumed) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", {63'h0, rdy}, 64'h0);
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_tag", {60'h0, dst}, {60'h0, e.tag});
                    check_eq("sb_result", {32'h0, r}, {32'h0, e.r});
                    check_eq("sb_flags", {57'h0, flags}, {57'h0, e.flags});
                end
            end
            if (taken) sb.push_back(fp_model(a, b, rmode, dsti));
        end
    endtask

    task automatic run_directed(input string name, input logic [31:0] a_v, input logic [31:0] b_v,
                                input logic rm_v, input logic [3:0] tag_v,
                                input logic [31:0] exp_r, input logic [6:0] exp_f);
        logic tk, cs;
        int   lat;
        lat = 0;
        step(1'b1, a_v, b_v, rm_v, tag_v, 1'b0, 1'b0, tk, cs);
        check_eq({name, "_ack"}, {63'h0, tk}, 64'h1);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, tk, cs);
            if (rdy) begin
                lat = i + 1;
                check_eq({name, "_r"}, {32'h0, r}, {32'h0, exp_r});
                check_eq({name, "_flags"}, {57'h0, flags}, {57'h0, exp_f});
                check_eq({name, "_dst"}, {60'h0, dst}, {60'h0, tag_v});
                break;
            end
        end
        check_eq({name, "_latency"}, 64'(lat), 64'd5);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        tk, cs, pend, pact, prm;
        logic [31:0] pa, pb, hold_r;
        logic [3:0]  ptag, hold_d, next_tag;
        logic [31:0] sa [8];
        logic [31:0] sb_op [8];
        int          idx, n_cons, n_rdy;

        act = 0; a = 0; b = 0; rmode = 0; dsti = 0; hold = 0; reset = 1;
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, tk, cs);
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, tk, cs);
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, tk, cs);
        check_eq("reset_rdy", {63'h0, rdy}, 64'h0);
        check_eq("reset_r", {32'h0, r}, 64'h0);
        check_eq("reset_dst", {60'h0, dst}, 64'h0);
        check_eq("reset_flags", {57'h0, flags}, 64'h0);
        check_eq("reset_ack", {63'h0, ack}, 64'h1);

        // flags: {ZERO, SIGN, INF, NAN, OVF, UNF, INX}
        run_directed("mul_1p5x2",  32'h3FC0_0000, 32'h4000_0000, 1'b0, 4'h5, 32'h4040_0000, 7'b0000000);
        run_directed("inf_x_zero", 32'h7F80_0000, 32'h0000_0000, 1'b0, 4'h1, 32'h7FC0_0000, 7'b0001000);
        run_directed("ninf_x_2",   32'hFF80_0000, 32'h4000_0000, 1'b0, 4'h2, 32'hFF80_0000, 7'b0110000);
        run_directed("ovf_rne",    32'h7F00_0000, 32'h4000_0000, 1'b0, 4'h3, 32'h7F80_0000, 7'b0010101);
        run_directed("ovf_rtz",    32'h7F00_0000, 32'h4000_0000, 1'b1, 4'h4, 32'h7F7F_FFFF, 7'b0000101);
        run_directed("rne_up",     32'h3F80_0001, 32'h3F80_0001, 1'b0, 4'h6, 32'h3F80_0002, 7'b0000001);
        run_directed("ones_rne",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 4'h7, 32'h407F_FFFE, 7'b0000001);
        run_directed("ones_rtz",   32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b1, 4'h8, 32'h407F_FFFE, 7'b0000001);
        run_directed("unf_flush",  32'h0080_0000, 32'h3F00_0000, 1'b0, 4'h9, 32'h0000_0000, 7'b1000011);
        run_directed("daz",        32'h8040_0000, 32'h3F80_0000, 1'b0, 4'hA, 32'h8000_0000, 7'b1100000);

        // Back-to-back burst with a three-cycle stall while a result is waiting.
        for (int i = 0; i < 8; i++) begin
            sa[i]    = rand_fp();
            sb_op[i] = rand_fp();
        end
        idx = 0; n_cons = 0; next_tag = 0; hold_r = 0; hold_d = 0;
        for (int c = 0; c < 30; c++) begin
            step(idx < 8, (idx < 8) ? sa[idx] : 32'h0, (idx < 8) ? sb_op[idx] : 32'h0,
                 1'(c & 1), 4'(idx), (c >= 7 && c <= 9), 1'b0, tk, cs);
            check_eq("stall_ack", {63'h0, ack}, {63'h0, !(c >= 7 && c <= 9)});
            if (c == 7) begin
                check_eq("stall_rdy", {63'h0, rdy}, 64'h1);
                hold_r = r;
                hold_d = dst;
            end else if (c == 8 || c == 9) begin
                check_eq("stall_r_stable", {32'h0, r}, {32'h0, hold_r});
                check_eq("stall_dst_stable", {60'h0, dst}, {60'h0, hold_d});
            end
            if (cs) begin
                check_eq("burst_order", {60'h0, dst}, {60'h0, next_tag});
                next_tag++;
                n_cons++;
            end
            if (tk) idx++;
        end
        check_eq("burst_count", 64'(n_cons), 64'd8);
        check_eq("burst_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rand_fp(), rand_fp(), 1'b0, 4'(i), 1'b0, 1'b0, tk, cs);
        end
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b1, tk, cs);
        step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, tk, cs);
        check_eq("rst_mid_rdy", {63'h0, rdy}, 64'h0);
        check_eq("rst_mid_dst", {60'h0, dst}, 64'h0);
        n_rdy = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, tk, cs);
            if (rdy) n_rdy++;
        end
        check_eq("rst_no_stale", 64'(n_rdy), 64'd0);

        // Randomized traffic with random back-pressure; a refused op is held until taken.
        pend = 0; pact = 0; pa = 0; pb = 0; prm = 0; ptag = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend) begin
                pact = ($urandom_range(0, 3) != 0);
                pa   = rand_fp();
                pb   = rand_fp();
                prm  = 1'($urandom);
                ptag = 4'($urandom);
                pend = pact;
            end
            step(pact, pa, pb, prm, ptag, ($urandom_range(0, 3) == 0), 1'b0, tk, cs);
            if (tk) pend = 0;
        end
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 1'b0, tk, cs);
        end
        check_eq("drain_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
